lockreg_write_arbiter: RTL and testbench
========================================

LOCKREG_WRITE_ARBITER -- requirements
Module: lockreg_write_arbiter

Interface
REQ-001 Parameter WIDTH, default 32, data width of each protected register.
REQ-002 Parameter NREG, fixed at 4, number of protected registers; addresses are 2 bits.
REQ-003 Clk  input  1  rising-edge clock.
REQ-004 resetn  input  1  reset; asynchronous assert, active-low.
REQ-005 h_valid / h_ready  input / output  1 / 1  host request handshake.
REQ-006 h_addr / h_data / h_lock  input  2 / WIDTH / 1  host target, write data, lock command (1 = set lock bit, no data write).
REQ-007 d_valid / d_ready  input / output  1 / 1  debug request handshake.
REQ-008 d_addr / d_data  input  2 / WIDTH  debug target and write data; debug port has no lock command.
REQ-009 debug_unlocked  input  1  debug write authorization.
REQ-010 resp_valid / resp_src / resp_err  output  1 / 1 / 1  one-cycle completion pulse; src 0 = host, 1 = debug; err 1 = rejected.
REQ-011 reg_q  output  NREG*WIDTH  register contents; register i at bits [i*WIDTH +: WIDTH].
REQ-012 lock_q  output  NREG  per-register sticky lock bits.

Function
REQ-013 FSM states: IDLE, CHECK, RESP; one transaction in flight at a time.
REQ-014 IDLE: exactly one of h_ready/d_ready is high, selected by arbitration; both low in CHECK and RESP.
REQ-015 Arbitration: if only one valid, grant it; if both valid, grant the requester not granted last; last_grant resets to debug, so host wins the first tie.
REQ-016 Handshake: valid & ready in cycle N latches src, addr, data, lock; state goes to CHECK in N+1.
REQ-017 Requesters hold valid and payload stable until ready; withdrawing valid before ready is legal and causes no transaction.
REQ-018 CHECK (cycle N+1): permission evaluated using lock_q and debug_unlocked sampled in that cycle.
REQ-019 Host write permitted iff lock_q[addr] == 0.
REQ-020 Debug write permitted iff lock_q[addr] == 0 and debug_unlocked == 1.
REQ-021 Host lock command always permitted; it sets lock_q[addr], leaves reg_q unchanged, and completes with err = 0 even if the lock bit is already set.
REQ-022 A permitted write updates the register at the end of CHECK; the new value is visible in cycle N+2. A rejected write leaves reg_q and lock_q unchanged.
REQ-023 RESP (cycle N+2): resp_valid = 1 for exactly one cycle, carrying resp_src and resp_err; the next state is IDLE.
REQ-024 Throughput: at most one transaction per 3 cycles; the next grant can occur in cycle N+3.
REQ-025 Lock bits are cleared only by reset; no input clears them.
REQ-026 No input other than the permission terms in REQ-019 to REQ-021 affects write permission.
REQ-027 A lock completed in transaction k applies to every transaction whose CHECK cycle follows it, including a debug write queued during transaction k.
REQ-028 resp_src, resp_err and the latched payload are don't-care when resp_valid = 0; reg_q and lock_q always reflect the current state.

Reset
REQ-029 resetn low immediately forces: state IDLE, reg_q all zero, lock_q = 0, resp_valid = resp_err = resp_src = 0, h_ready = d_ready = 0, last_grant = debug.
REQ-030 Reset during CHECK or RESP aborts the transaction: no register write, no lock set, no response.
REQ-031 Ready outputs stay low while resetn is low; arbitration resumes on the first clock edge after deassertion.

Verification
REQ-032 Host write addr 2, data 0xDEADBEEF, lock_q = 0 -> reg_q[2] = 0xDEADBEEF at N+2; resp_valid = 1, src = 0, err = 0 at N+2.
REQ-033 Host lock addr 1, then host write addr 1, data 0x12345678 -> lock_q = 4'b0010; second resp err = 1; reg_q[1] stays 0.
REQ-034 Debug write addr 0, data 0xA5A5A5A5: debug_unlocked = 0 -> err = 1, reg_q[0] = 0; debug_unlocked = 1 -> err = 0, reg_q[0] = 0xA5A5A5A5; debug_unlocked = 1 with lock_q[0] = 1 -> err = 1.
REQ-035 h_valid and d_valid held high continuously from reset -> grants alternate host, debug, host, ..., one grant every 3 cycles.
REQ-036 resetn pulsed low during CHECK of a host write addr 3, data 0xFFFFFFFF -> reg_q[3] = 0, no resp_valid pulse, lock_q = 0.
REQ-037 Host lock addr 3 while a debug write to addr 3 is pending -> host wins the tie; the debug CHECK sees lock_q[3] = 1 and completes with err = 1.

Source files
------------

// File: rtl/lockreg_write_arbiter.sv
// Arbitrates host and debug writes into NREG protected registers with sticky per-register locks.
// One transaction at a time: grant in IDLE, permission check and commit in CHECK, response pulse in RESP.
module lockreg_write_arbiter #(
    parameter int WIDTH = 32,
    parameter int NREG  = 4
) (
    input  logic                    Clk,
    input  logic                    resetn,
    input  logic                    h_valid,
    output logic                    h_ready,
    input  logic [1:0]              h_addr,
    input  logic [WIDTH-1:0]        h_data,
    input  logic                    h_lock,
    input  logic                    d_valid,
    output logic                    d_ready,
    input  logic [1:0]              d_addr,
    input  logic [WIDTH-1:0]        d_data,
    input  logic                    debug_unlocked,
    output logic                    resp_valid,
    output logic                    resp_src,
    output logic                    resp_err,
    output logic [NREG*WIDTH-1:0]   reg_q,
    output logic [NREG-1:0]         lock_q
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic               r_run;
    logic               r_last_grant;
    logic               r_src;
    logic [1:0]         r_addr;
    logic [WIDTH-1:0]   r_data;
    logic               r_lock;
    logic               r_err;
    logic [WIDTH-1:0]   r_regs [NREG];
    logic [NREG-1:0]    r_lock_q;

    logic               w_grant_h;
    logic               w_grant_d;
    logic               w_resp;
    logic               w_permit;

    // r_run holds ready low until the first clock edge after reset is released.
    always_comb begin
        w_next_state = r_state;
        w_grant_h    = 1'b0;
        w_grant_d    = 1'b0;
        w_resp       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_run) begin
                    if (h_valid && !d_valid)
                        w_grant_h = 1'b1;
                    else if (d_valid && !h_valid)
                        w_grant_d = 1'b1;
                    else if (r_last_grant)
                        w_grant_h = 1'b1;
                    else
                        w_grant_d = 1'b1;
                    if ((w_grant_h && h_valid) || (w_grant_d && d_valid))
                        w_next_state = ST_CHECK;
                end
            end
            ST_CHECK: w_next_state = ST_RESP;
            ST_RESP: begin
                w_resp       = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Lock commands always succeed; writes need an open lock and, for debug, authorization.
    always_comb begin
        w_permit = r_lock | (~r_lock_q[r_addr] & (~r_src | debug_unlocked));
    end

    always_ff @(posedge Clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= ST_IDLE;
            r_run        <= 1'b0;
            r_last_grant <= 1'b1;
            r_src        <= 1'b0;
            r_addr       <= '0;
            r_data       <= '0;
            r_lock       <= 1'b0;
            r_err        <= 1'b0;
            r_lock_q     <= '0;
            for (int i = 0; i < NREG; i++)
                r_regs[i] <= '0;
        end else begin
            r_state <= w_next_state;
            r_run   <= 1'b1;
            if (r_state == ST_IDLE && w_next_state == ST_CHECK) begin
                r_src        <= w_grant_d;
                r_addr       <= w_grant_d ? d_addr : h_addr;
                r_data       <= w_grant_d ? d_data : h_data;
                r_lock       <= w_grant_h & h_lock;
                r_last_grant <= w_grant_d;
            end
            if (r_state == ST_CHECK) begin
                r_err <= ~w_permit;
                if (w_permit) begin
                    if (r_lock)
                        r_lock_q[r_addr] <= 1'b1;
                    else
                        r_regs[r_addr] <= r_data;
                end
            end
        end
    end

    assign h_ready    = w_grant_h;
    assign d_ready    = w_grant_d;
    assign resp_valid = w_resp;
    assign resp_src   = r_src;
    assign resp_err   = r_err;
    assign lock_q     = r_lock_q;

    for (genvar g = 0; g < NREG; g++) begin : g_reg_out
        assign reg_q[g*WIDTH +: WIDTH] = r_regs[g];
    end

endmodule

// File: tb/tb_lockreg_write_arbiter.sv
// Directed bench for lockreg_write_arbiter: a vector table of single transactions plus
// hand-written sequences for reset, tie alternation, abort and lock-vs-debug races.
module tb_lockreg_write_arbiter;

    localparam int WIDTH = 32;
    localparam int NREG  = 4;

    logic                  Clk = 1'b0;
    logic                  resetn = 1'b0;
    logic                  h_valid = 1'b0;
    logic                  h_ready;
    logic [1:0]            h_addr = '0;
    logic [WIDTH-1:0]      h_data = '0;
    logic                  h_lock = 1'b0;
    logic                  d_valid = 1'b0;
    logic                  d_ready;
    logic [1:0]            d_addr = '0;
    logic [WIDTH-1:0]      d_data = '0;
    logic                  debug_unlocked = 1'b0;
    logic                  resp_valid;
    logic                  resp_src;
    logic                  resp_err;
    logic [NREG*WIDTH-1:0] reg_q;
    logic [NREG-1:0]       lock_q;

    int n_tests = 0;
    int n_fail  = 0;

    lockreg_write_arbiter #(.WIDTH(WIDTH), .NREG(NREG)) dut (
        .Clk(Clk), .resetn(resetn),
        .h_valid(h_valid), .h_ready(h_ready), .h_addr(h_addr), .h_data(h_data), .h_lock(h_lock),
        .d_valid(d_valid), .d_ready(d_ready), .d_addr(d_addr), .d_data(d_data),
        .debug_unlocked(debug_unlocked),
        .resp_valid(resp_valid), .resp_src(resp_src), .resp_err(resp_err),
        .reg_q(reg_q), .lock_q(lock_q)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic        src;
        logic [1:0]  addr;
        logic [31:0] data;
        logic        lock;
        logic        unl;
        logic        exp_err;
        logic [3:0]  exp_lock;
        logic [31:0] exp_reg;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] reg_at(input logic [1:0] a);
        return reg_q[a*WIDTH +: WIDTH];
    endfunction

    task automatic do_reset();
        @(negedge Clk);
        resetn = 1'b0;
        h_valid = 1'b0;
        d_valid = 1'b0;
        repeat (2) @(negedge Clk);
        resetn = 1'b1;
    endtask

    // Called just after a negedge with valids driven; returns once the chosen port is ready.
    task automatic wait_ready(input logic src, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if ((src == 1'b0 && h_ready) || (src == 1'b1 && d_ready)) begin
                ok = 1'b1;
                return;
            end
            @(negedge Clk);
        end
    endtask

    task automatic run_vec(input int idx);
        vec_t v;
        bit   ok;
        v = vecs[idx];
        @(negedge Clk);
        debug_unlocked = v.unl;
        if (v.src == 1'b0) begin
            h_valid = 1'b1; h_addr = v.addr; h_data = v.data; h_lock = v.lock;
        end else begin
            d_valid = 1'b1; d_addr = v.addr; d_data = v.data;
        end
        wait_ready(v.src, ok);
        chk($sformatf("vec%0d_grant", idx), {63'd0, ok}, 64'd1);
        if (!ok) begin
            h_valid = 1'b0; d_valid = 1'b0;
            return;
        end
        @(posedge Clk); #1;
        h_valid = 1'b0; d_valid = 1'b0;
        chk($sformatf("vec%0d_check_noresp", idx), {63'd0, resp_valid}, 64'd0);
        @(posedge Clk); #1;
        chk($sformatf("vec%0d_resp_valid", idx), {63'd0, resp_valid}, 64'd1);
        chk($sformatf("vec%0d_resp_src", idx), {63'd0, resp_src}, {63'd0, v.src});
        chk($sformatf("vec%0d_resp_err", idx), {63'd0, resp_err}, {63'd0, v.exp_err});
        chk($sformatf("vec%0d_reg", idx), {32'd0, reg_at(v.addr)}, {32'd0, v.exp_reg});
        chk($sformatf("vec%0d_lock", idx), {60'd0, lock_q}, {60'd0, v.exp_lock});
        @(posedge Clk); #1;
        chk($sformatf("vec%0d_resp_one_cycle", idx), {63'd0, resp_valid}, 64'd0);
    endtask

    initial begin
        // src addr data lock unl | err lock_q reg[addr]
        vecs[0]  = '{1'b0, 2'd2, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 4'b0000, 32'hDEADBEEF};
        vecs[1]  = '{1'b0, 2'd1, 32'h00000000, 1'b1, 1'b0, 1'b0, 4'b0010, 32'h00000000};
        vecs[2]  = '{1'b0, 2'd1, 32'h12345678, 1'b0, 1'b0, 1'b1, 4'b0010, 32'h00000000};
        vecs[3]  = '{1'b1, 2'd0, 32'hA5A5A5A5, 1'b0, 1'b0, 1'b1, 4'b0010, 32'h00000000};
        vecs[4]  = '{1'b1, 2'd0, 32'hA5A5A5A5, 1'b0, 1'b1, 1'b0, 4'b0010, 32'hA5A5A5A5};
        vecs[5]  = '{1'b0, 2'd0, 32'h00000000, 1'b1, 1'b1, 1'b0, 4'b0011, 32'hA5A5A5A5};
        vecs[6]  = '{1'b1, 2'd0, 32'h12345678, 1'b0, 1'b1, 1'b1, 4'b0011, 32'hA5A5A5A5};
        vecs[7]  = '{1'b0, 2'd1, 32'hFFFF0000, 1'b1, 1'b0, 1'b0, 4'b0011, 32'h00000000};
        vecs[8]  = '{1'b0, 2'd2, 32'h01020304, 1'b0, 1'b0, 1'b0, 4'b0011, 32'h01020304};
        vecs[9]  = '{1'b1, 2'd3, 32'hCAFEF00D, 1'b0, 1'b1, 1'b0, 4'b0011, 32'hCAFEF00D};
        vecs[10] = '{1'b0, 2'd0, 32'h0BADF00D, 1'b0, 1'b0, 1'b1, 4'b0011, 32'hA5A5A5A5};

        // Reset state, with both requesters asserting valid.
        h_valid = 1'b1; d_valid = 1'b1;
        #7;
        chk("rst_h_ready", {63'd0, h_ready}, 64'd0);
        chk("rst_d_ready", {63'd0, d_ready}, 64'd0);
        chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
        chk("rst_reg_q", {{(64-NREG*WIDTH+64){1'b0}}, 64'd0} == 128'd0 ? {63'd0, reg_q == '0} : 64'd0, 64'd1);
        chk("rst_lock_q", {60'd0, lock_q}, 64'd0);
        h_valid = 1'b0; d_valid = 1'b0;
        @(negedge Clk);
        resetn = 1'b1;

        for (int i = 0; i < 11; i++)
            run_vec(i);

        // Both valid held from reset: grants alternate H,D,... three cycles apart.
        begin
            int g_src [6];
            int g_cyc [6];
            int ng = 0;
            do_reset();
            h_valid = 1'b1; h_addr = 2'd2; h_data = 32'h11; h_lock = 1'b0;
            d_valid = 1'b1; d_addr = 2'd1; d_data = 32'h22; debug_unlocked = 1'b1;
            for (int c = 0; c < 40 && ng < 6; c++) begin
                #1;
                if (h_ready || d_ready) begin
                    g_src[ng] = d_ready ? 1 : 0;
                    g_cyc[ng] = c;
                    ng++;
                end
                @(negedge Clk);
            end
            h_valid = 1'b0; d_valid = 1'b0;
            chk("alt_grant_count", 64'(ng), 64'd6);
            for (int k = 0; k < ng; k++) begin
                chk($sformatf("alt_src%0d", k), 64'(g_src[k]), 64'(k % 2));
                if (k > 0)
                    chk($sformatf("alt_gap%0d", k), 64'(g_cyc[k] - g_cyc[k-1]), 64'd3);
            end
        end

        // Reset pulsed during CHECK of a host write: no write, no response.
        begin
            bit ok;
            bit saw_resp = 1'b0;
            do_reset();
            h_valid = 1'b1; h_addr = 2'd3; h_data = 32'hFFFFFFFF; h_lock = 1'b0;
            wait_ready(1'b0, ok);
            chk("abort_grant", {63'd0, ok}, 64'd1);
            @(posedge Clk); #1;
            h_valid = 1'b0;
            @(negedge Clk);
            resetn = 1'b0;
            #1;
            chk("abort_rst_h_ready", {63'd0, h_ready}, 64'd0);
            #2;
            resetn = 1'b1;
            for (int c = 0; c < 5; c++) begin
                @(negedge Clk);
                if (resp_valid) saw_resp = 1'b1;
            end
            chk("abort_no_resp", {63'd0, saw_resp}, 64'd0);
            chk("abort_reg3", {32'd0, reg_at(2'd3)}, 64'd0);
            chk("abort_lock", {60'd0, lock_q}, 64'd0);
        end

        // Host lock on addr 3 ties with a debug write to addr 3; debug must be rejected.
        begin
            bit ok;
            do_reset();
            debug_unlocked = 1'b1;
            h_valid = 1'b1; h_addr = 2'd3; h_data = 32'h0; h_lock = 1'b1;
            d_valid = 1'b1; d_addr = 2'd3; d_data = 32'h55AA55AA;
            wait_ready(1'b0, ok);
            chk("race_host_first", {63'd0, ok}, 64'd1);
            chk("race_d_not_ready", {63'd0, d_ready}, 64'd0);
            @(posedge Clk); #1;
            h_valid = 1'b0; h_lock = 1'b0;
            @(posedge Clk); #1;
            chk("race_r1_valid", {63'd0, resp_valid}, 64'd1);
            chk("race_r1_src", {63'd0, resp_src}, 64'd0);
            chk("race_r1_err", {63'd0, resp_err}, 64'd0);
            chk("race_r1_lock", {60'd0, lock_q}, 64'h8);
            @(negedge Clk);
            wait_ready(1'b1, ok);
            chk("race_debug_grant", {63'd0, ok}, 64'd1);
            @(posedge Clk); #1;
            d_valid = 1'b0;
            @(posedge Clk); #1;
            chk("race_r2_valid", {63'd0, resp_valid}, 64'd1);
            chk("race_r2_src", {63'd0, resp_src}, 64'd1);
            chk("race_r2_err", {63'd0, resp_err}, 64'd1);
            chk("race_r2_reg3", {32'd0, reg_at(2'd3)}, 64'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
